mac_frame_generator: RTL and testbench
======================================

Name: mac_frame_generator

Overview:
- Transmit-side counterpart of the MAC frame checker.
- Builds complete Ethernet frames from a start request and emits them on the 64-bit data / 8-bit control lane interface, one word per clock. Each frame is START, preamble, SFD, DA, SA, length/type, payload, pad, FCS, TERM, followed by IDLE fill.
- The payload is an internal incrementing-byte pattern, so the testbench can drive the checker end-to-end.
- Supports FCS error injection for negative testing.

Parameters:
- DATA_WIDTH, 64, data bus width; 8 byte lanes, lane 0 = bits [7:0], transmitted first.
- CTRL_WIDTH, 8, one control bit per lane; 1 = control character.
- IDLE_CODE, 8'h07, idle control character.
- START_CODE, 8'hFB, start control character.
- TERM_CODE, 8'hFD, terminate control character.
- PREAMBLE_CODE, 8'h55, preamble byte.
- SFD_CODE, 8'hD5, start-of-frame delimiter.
- DST_ADDR_CODE, 48'hFFFFFFFFFFFF, destination address; bits [47:40] are sent first.
- SRC_ADDR_CODE, 48'h123456789ABC, source address; bits [47:40] are sent first.
- IPG_CYCLES, 2, minimum all-idle words after the TERM word.

Ports:
- clk  in  1  clock.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_start  in  1  frame request; accepted only when o_ready=1.
- i_payload_len  in  11  payload byte count; sampled at accept.
- i_payload_seed  in  8  first payload byte; sampled at accept.
- i_fcs_corrupt  in  1  when 1 at accept, the transmitted FCS has bit 0 inverted.
- o_tx_data  out  64  lane data.
- o_tx_ctrl  out  8  lane control flags.
- o_ready  out  1  generator idle and IPG satisfied.
- o_frame_done  out  1  one-cycle pulse in the TERM word cycle.
- o_len_err  out  1  one-cycle pulse at accept if i_payload_len > 1500.
- o_frame_count  out  32  frames completed; wraps at 2^32.

Behaviour:
- Reset values (asynchronous, effective immediately, including mid-frame):
  - o_tx_data = {8{IDLE_CODE}}, o_tx_ctrl = 8'hFF.
  - o_ready = 1, o_frame_done = 0, o_len_err = 0, o_frame_count = 0.
  - FSM goes to IDLE and the IPG counter clears. A reset mid-frame truncates the frame with no TERM.
- FSM states: IDLE -> SEND -> IPG -> IDLE.
  - IDLE: outputs all-idle words. i_start=1 accepts the request and moves to SEND.
  - SEND: one word per cycle until the word containing TERM.
  - IPG: outputs IPG_CYCLES all-idle words, then IDLE.
  - i_start outside IDLE is ignored. There is no queuing.
- Latency: a request accepted at edge T produces the START word on the outputs after edge T+1. Outputs are registered.
- Payload length rules:
  - L = min(i_payload_len, 1500). Values above 1500 pulse o_len_err and are clamped.
  - P = max(L, 46). Bytes L..P-1 are 8'h00 pad.
  - Payload byte k = (seed + k) mod 256.
  - The length/type field equals L, sent high byte first.
- Frame byte stream, indices b = 0..N-1:
  - b0 = START_CODE, ctrl=1.
  - b1..b6 = PREAMBLE_CODE.
  - b7 = SFD_CODE.
  - b8..13 = DA.
  - b14..19 = SA.
  - b20..21 = length/type.
  - b22..22+P-1 = payload and pad.
  - Next 4 bytes = FCS.
  - Then TERM_CODE, ctrl=1.
  - N = 27 + P.
- Word mapping: word w carries bytes 8w..8w+7, with byte 8w in lane 0. Lanes after TERM in the same word are IDLE_CODE with ctrl=1. All other data lanes have ctrl=0.
- FCS rules:
  - IEEE 802.3 CRC-32, computed over DA through the end of pad.
  - Reflected polynomial 32'hEDB88320, init 32'hFFFFFFFF, final complement.
  - Transmitted least-significant byte first.
  - The CRC is updated combinationally across all data lanes of a word, so FCS bytes may share a word with payload bytes and with TERM.
- Counters: o_frame_done and the o_frame_count increment occur in the TERM word cycle. o_ready = 1 only in IDLE.
- Back-to-back requests: with i_start held high, the next START word follows exactly IPG_CYCLES all-idle words after the TERM word.

Test Plan:
- L=46, seed=8'h00, corrupt=0:
  - 10 words; word 0 = 64'hD5555555555555FB, ctrl 8'h01.
  - TERM in word 9 lane 0, word 9 ctrl 8'hFF.
  - Checker reports no errors. FCS matches the golden CRC-32 model. o_frame_done pulses once.
- L=10, seed=8'hA0:
  - Length field 16'h000A; payload A0..A9 followed by 36 zero pad bytes.
  - 10 words in total; checker reports no errors.
- L=1500, seed=8'hFF:
  - 191 words; TERM in word 190 lane 6, word 190 ctrl 8'hC0.
  - Payload wraps FF, 00, 01 and so on. FCS matches the model.
- L=47, corrupt=1:
  - TERM in word 9 lane 1.
  - Transmitted FCS differs from the golden value only in bit 0; checker flags fcs_error=1 and no other errors.
- i_payload_len=1600:
  - o_len_err pulses for 1 cycle and the frame is generated with L=1500.
- i_start held high for 3 frames, then i_rst_n asserted mid-frame 4:
  - Exactly 2 all-idle words separate consecutive frames; o_frame_count = 3.
  - On reset the outputs go to all-idle (ctrl 8'hFF) immediately and the count returns to 0.

Source files
------------

// File: rtl/mac_frame_generator.sv
// Transmit-side Ethernet frame builder: emits START..TERM frames with an
// incrementing-byte payload on a 64-bit data / 8-bit control lane interface.
module mac_frame_generator #(
    parameter int          DATA_WIDTH    = 64,
    parameter int          CTRL_WIDTH    = 8,
    parameter logic [7:0]  IDLE_CODE     = 8'h07,
    parameter logic [7:0]  START_CODE    = 8'hFB,
    parameter logic [7:0]  TERM_CODE     = 8'hFD,
    parameter logic [7:0]  PREAMBLE_CODE = 8'h55,
    parameter logic [7:0]  SFD_CODE      = 8'hD5,
    parameter logic [47:0] DST_ADDR_CODE = 48'hFFFFFFFFFFFF,
    parameter logic [47:0] SRC_ADDR_CODE = 48'h123456789ABC,
    parameter int          IPG_CYCLES    = 2
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [10:0]           i_payload_len,
    input  logic [7:0]            i_payload_seed,
    input  logic                  i_fcs_corrupt,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic [CTRL_WIDTH-1:0] o_tx_ctrl,
    output logic                  o_ready,
    output logic                  o_frame_done,
    output logic                  o_len_err,
    output logic [31:0]           o_frame_count
);

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_IPG} state_t;

    state_t                  state_q;
    logic [7:0]              word_q;
    logic [31:0]             crc_q, crc_d;
    logic [10:0]             len_q, fcs_pos_q, term_pos_q;
    logic [7:0]              seed_q;
    logic                    corrupt_q;
    logic [7:0]              ipg_q;
    logic [DATA_WIDTH-1:0]   data_q, word_data;
    logic [CTRL_WIDTH-1:0]   ctrl_q, word_ctrl;
    logic                    done_q, len_err_q, word_last;
    logic [31:0]             count_q;

    logic [10:0] len_clamp, pad_len;
    assign len_clamp = (i_payload_len > 11'd1500) ? 11'd1500 : i_payload_len;
    assign pad_len   = (len_clamp < 11'd46) ? 11'd46 : len_clamp;

    function automatic logic [31:0] crc_next(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in ^ {24'h0, d};
        for (int j = 0; j < 8; j++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    // Each lane's byte is derived from its absolute frame index; the CRC is
    // chained across lanes so FCS bytes can follow payload in the same word.
    logic [31:0] crc_run, fcs_v;
    logic [10:0] b, k;
    logic [7:0]  byte_v;
    logic        ctl_v, in_crc;
    logic [1:0]  fcs_idx;
    logic [5:0]  sh;

    always_comb begin
        word_data = '0;
        word_ctrl = '0;
        word_last = 1'b0;
        crc_run   = crc_q;
        b = '0; k = '0; byte_v = IDLE_CODE; ctl_v = 1'b1; in_crc = 1'b0;
        fcs_idx = '0; sh = '0; fcs_v = '0;
        for (int i = 0; i < 8; i++) begin
            b       = {word_q, 3'b000} + 11'(i);
            k       = b - 11'd22;
            fcs_idx = 2'(b - fcs_pos_q);
            fcs_v   = ~crc_run;
            sh      = '0;
            byte_v  = IDLE_CODE;
            ctl_v   = 1'b1;
            in_crc  = 1'b0;
            if (b == 11'd0) begin
                byte_v = START_CODE;
            end else if (b < 11'd7) begin
                byte_v = PREAMBLE_CODE; ctl_v = 1'b0;
            end else if (b == 11'd7) begin
                byte_v = SFD_CODE; ctl_v = 1'b0;
            end else if (b < 11'd14) begin
                sh = 6'((11'd13 - b) << 3);
                byte_v = 8'(DST_ADDR_CODE >> sh); ctl_v = 1'b0; in_crc = 1'b1;
            end else if (b < 11'd20) begin
                sh = 6'((11'd19 - b) << 3);
                byte_v = 8'(SRC_ADDR_CODE >> sh); ctl_v = 1'b0; in_crc = 1'b1;
            end else if (b == 11'd20) begin
                byte_v = {5'b0, len_q[10:8]}; ctl_v = 1'b0; in_crc = 1'b1;
            end else if (b == 11'd21) begin
                byte_v = len_q[7:0]; ctl_v = 1'b0; in_crc = 1'b1;
            end else if (b < fcs_pos_q) begin
                byte_v = (k < len_q) ? (seed_q + k[7:0]) : 8'h00;
                ctl_v = 1'b0; in_crc = 1'b1;
            end else if (b < term_pos_q) begin
                byte_v = 8'(fcs_v >> {fcs_idx, 3'b000});
                if (fcs_idx == 2'd0 && corrupt_q) byte_v[0] = ~byte_v[0];
                ctl_v = 1'b0;
            end else if (b == term_pos_q) begin
                byte_v = TERM_CODE; word_last = 1'b1;
            end
            if (in_crc) crc_run = crc_next(crc_run, byte_v);
            word_data[8*i +: 8] = byte_v;
            word_ctrl[i]        = ctl_v;
        end
        crc_d = crc_run;
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            word_q     <= '0;
            crc_q      <= '1;
            len_q      <= '0;
            fcs_pos_q  <= '0;
            term_pos_q <= '0;
            seed_q     <= '0;
            corrupt_q  <= 1'b0;
            ipg_q      <= '0;
            data_q     <= {8{IDLE_CODE}};
            ctrl_q     <= '1;
            done_q     <= 1'b0;
            len_err_q  <= 1'b0;
            count_q    <= '0;
        end else begin
            done_q    <= 1'b0;
            len_err_q <= 1'b0;
            data_q    <= {8{IDLE_CODE}};
            ctrl_q    <= '1;
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        state_q    <= ST_SEND;
                        word_q     <= '0;
                        crc_q      <= '1;
                        len_q      <= len_clamp;
                        fcs_pos_q  <= pad_len + 11'd22;
                        term_pos_q <= pad_len + 11'd26;
                        seed_q     <= i_payload_seed;
                        corrupt_q  <= i_fcs_corrupt;
                        len_err_q  <= (i_payload_len > 11'd1500);
                    end
                end
                ST_SEND: begin
                    data_q <= word_data;
                    ctrl_q <= word_ctrl;
                    crc_q  <= crc_d;
                    word_q <= word_q + 8'd1;
                    if (word_last) begin
                        done_q  <= 1'b1;
                        count_q <= count_q + 32'd1;
                        ipg_q   <= 8'(IPG_CYCLES - 1);
                        // The idle word emitted in the accepting IDLE cycle is the last gap word.
                        state_q <= (IPG_CYCLES > 1) ? ST_IPG : ST_IDLE;
                    end
                end
                ST_IPG: begin
                    if (ipg_q <= 8'd1) state_q <= ST_IDLE;
                    else               ipg_q   <= ipg_q - 8'd1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_tx_data     = data_q;
    assign o_tx_ctrl     = ctrl_q;
    assign o_ready       = (state_q == ST_IDLE);
    assign o_frame_done  = done_q;
    assign o_len_err     = len_err_q;
    assign o_frame_count = count_q;

endmodule

// File: tb/tb_mac_frame_generator.sv
// Bench for mac_frame_generator: frame-level reference model built from byte
// rules, per-cycle comparison, directed cases and randomized requests.
module tb_mac_frame_generator;

    localparam int          IPG    = 2;
    localparam logic [63:0] IDLE_W = {8{8'h07}};

    logic        clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [10:0] i_payload_len = '0;
    logic [7:0]  i_payload_seed = '0;
    logic        i_fcs_corrupt = 1'b0;
    logic [63:0] o_tx_data;
    logic [7:0]  o_tx_ctrl;
    logic        o_ready, o_frame_done, o_len_err;
    logic [31:0] o_frame_count;

    always #5 clk = ~clk;

    mac_frame_generator dut (
        .clk(clk), .i_rst_n(i_rst_n), .i_start(i_start),
        .i_payload_len(i_payload_len), .i_payload_seed(i_payload_seed),
        .i_fcs_corrupt(i_fcs_corrupt), .o_tx_data(o_tx_data), .o_tx_ctrl(o_tx_ctrl),
        .o_ready(o_ready), .o_frame_done(o_frame_done), .o_len_err(o_len_err),
        .o_frame_count(o_frame_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc32(input logic [7:0] a[0:1535], input int from, input int cnt);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < cnt; i++) begin
            c = c ^ {24'h0, a[from+i]};
            for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    // Lays the whole frame out as a byte list, then slices it into words:
    // word = {last, ctrl[7:0], data[63:0]}.
    function automatic void build_frame(input int len, input logic [7:0] seed, input bit corrupt,
                                        output logic [72:0] w[0:191], output int nw);
        logic [7:0]  fb[0:1535];
        bit          fc[0:1535];
        logic [47:0] da, sa;
        logic [15:0] lt;
        logic [31:0] fcs;
        int n, L, P;
        for (int i = 0; i < 1536; i++) begin fb[i] = 8'h07; fc[i] = 1'b1; end
        for (int i = 0; i < 192; i++) w[i] = '0;
        da = 48'hFFFFFFFFFFFF;
        sa = 48'h123456789ABC;
        L  = (len > 1500) ? 1500 : len;
        P  = (L < 46) ? 46 : L;
        lt = 16'(L);
        n  = 0;
        fb[n] = 8'hFB; fc[n] = 1'b1; n++;
        for (int i = 0; i < 6; i++) begin fb[n] = 8'h55; fc[n] = 1'b0; n++; end
        fb[n] = 8'hD5; fc[n] = 1'b0; n++;
        for (int i = 0; i < 6; i++) begin fb[n] = da[47-8*i -: 8]; fc[n] = 1'b0; n++; end
        for (int i = 0; i < 6; i++) begin fb[n] = sa[47-8*i -: 8]; fc[n] = 1'b0; n++; end
        fb[n] = lt[15:8]; fc[n] = 1'b0; n++;
        fb[n] = lt[7:0];  fc[n] = 1'b0; n++;
        for (int k = 0; k < P; k++) begin
            fb[n] = (k < L) ? 8'((int'(seed) + k) % 256) : 8'h00;
            fc[n] = 1'b0; n++;
        end
        fcs = crc32(fb, 8, n - 8);
        if (corrupt) fcs[0] = ~fcs[0];
        for (int j = 0; j < 4; j++) begin fb[n] = fcs[8*j +: 8]; fc[n] = 1'b0; n++; end
        fb[n] = 8'hFD; fc[n] = 1'b1; n++;
        nw = (n + 7) / 8;
        for (int wi = 0; wi < nw; wi++) begin
            for (int i = 0; i < 8; i++) begin
                w[wi][8*i +: 8] = fb[8*wi+i];
                w[wi][64+i]     = fc[8*wi+i];
            end
            w[wi][72] = (wi == nw - 1);
        end
    endfunction

    // Reference model: frame words queued at accept, one popped per cycle,
    // then IPG idle words before another request can be taken.
    logic [72:0] exp_q[$];
    logic [72:0] mw[0:191];
    logic [72:0] e;
    int          mn;
    int          gap = 0;
    logic [63:0] exp_data = IDLE_W;
    logic [7:0]  exp_ctrl = 8'hFF;
    logic        exp_done = 1'b0, exp_len_err = 1'b0, exp_ready = 1'b1;
    logic [31:0] exp_cnt = '0;

    always @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            exp_q.delete();
            gap = 0; exp_data = IDLE_W; exp_ctrl = 8'hFF;
            exp_done = 1'b0; exp_len_err = 1'b0; exp_ready = 1'b1; exp_cnt = '0;
        end else begin
            exp_done = 1'b0; exp_len_err = 1'b0;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                exp_data = e[63:0];
                exp_ctrl = e[71:64];
                if (e[72]) begin exp_done = 1'b1; exp_cnt = exp_cnt + 1; gap = IPG; end
            end else begin
                exp_data = IDLE_W; exp_ctrl = 8'hFF;
                if (i_start && gap <= 1) begin
                    build_frame(int'(i_payload_len), i_payload_seed, i_fcs_corrupt, mw, mn);
                    for (int i = 0; i < mn; i++) exp_q.push_back(mw[i]);
                    exp_len_err = (i_payload_len > 11'd1500);
                end
                if (gap > 0) gap--;
            end
            exp_ready = (exp_q.size() == 0) && (gap <= 1);
        end
    end

    // Per-cycle compare plus capture of the most recent DUT frame and gap lengths.
    logic [71:0] cap_w[0:191];
    int cap_n = 0, last_n = 0, idle_run = 0, le_cnt = 0;
    bit capturing = 1'b0, have_prev = 1'b0;
    int gap_q[$];

    always @(negedge clk) begin
        if (!i_rst_n) begin
            capturing = 1'b0; have_prev = 1'b0; idle_run = 0;
        end else begin
            check("cycle", 128'({o_tx_data, o_tx_ctrl, o_frame_done, o_len_err, o_ready, o_frame_count}),
                  128'({exp_data, exp_ctrl, exp_done, exp_len_err, exp_ready, exp_cnt}));
            if (o_len_err) le_cnt++;
            if (o_tx_ctrl[0] && o_tx_data[7:0] == 8'hFB && !capturing) begin
                if (have_prev) gap_q.push_back(idle_run);
                capturing = 1'b1; cap_n = 0;
            end
            if (capturing) begin
                if (cap_n < 192) cap_w[cap_n] = {o_tx_ctrl, o_tx_data};
                cap_n++;
                if (o_frame_done) begin
                    capturing = 1'b0; have_prev = 1'b1; idle_run = 0; last_n = cap_n;
                end
            end else if (o_tx_ctrl == 8'hFF && o_tx_data == IDLE_W) begin
                idle_run++;
            end
        end
    end

    task automatic wait_ready(input int budget);
        for (int i = 0; i < budget && !o_ready; i++) @(negedge clk);
        check("ready_wait", 128'(o_ready), 128'(1));
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (o_frame_done) begin seen = 1'b1; break; end
        end
        check("done_wait", 128'(seen), 128'(1));
    endtask

    task automatic run_frame(input int len, input logic [7:0] seed, input logic corrupt);
        wait_ready(400);
        last_n         = 0;
        i_payload_len  = 11'(len);
        i_payload_seed = seed;
        i_fcs_corrupt  = corrupt;
        i_start        = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        wait_done(400);
        repeat (2) @(negedge clk);
    endtask

    logic [72:0] pw[0:191], pw2[0:191];
    int          pn, pn2, diffs;
    logic [7:0]  s9[0:1535];

    initial begin
        repeat (3) @(negedge clk);
        check("rst_data",  128'(o_tx_data), 128'(IDLE_W));
        check("rst_ctrl",  128'(o_tx_ctrl), 128'(8'hFF));
        check("rst_ready", 128'(o_ready), 128'(1));
        check("rst_done",  128'(o_frame_done), 128'(0));
        check("rst_lenerr", 128'(o_len_err), 128'(0));
        check("rst_count", 128'(o_frame_count), 128'(0));
        i_rst_n = 1'b1;
        @(negedge clk);

        // Pin the model with hand-known values.
        for (int i = 0; i < 1536; i++) s9[i] = 8'h00;
        for (int i = 0; i < 9; i++) s9[i] = 8'h31 + 8'(i);
        check("crc_pin", 128'(crc32(s9, 0, 9)), 128'(32'hCBF43926));
        build_frame(46, 8'h00, 1'b0, pw, pn);
        check("model_l46_words", 128'(pn), 128'(10));
        check("model_l46_w0", 128'(pw[0][71:0]), 128'({8'h01, 64'hD5555555555555FB}));
        check("model_l46_w9", 128'(pw[9][71:0]), 128'({8'hFF, {7{8'h07}}, 8'hFD}));

        run_frame(46, 8'h00, 1'b0);
        check("l46_words", 128'(last_n), 128'(10));
        check("l46_w0", 128'(cap_w[0]), 128'({8'h01, 64'hD5555555555555FB}));
        check("l46_w9_ctrl", 128'(cap_w[9][71:64]), 128'(8'hFF));

        run_frame(10, 8'hA0, 1'b0);
        check("l10_words", 128'(last_n), 128'(10));
        check("l10_w2", 128'(cap_w[2][63:0]), 128'(64'hA1A00A00BC9A7856));

        run_frame(1500, 8'hFF, 1'b0);
        check("l1500_words", 128'(last_n), 128'(191));
        check("l1500_w190_ctrl", 128'(cap_w[190][71:64]), 128'(8'hC0));
        check("l1500_w190_term", 128'(cap_w[190][55:48]), 128'(8'hFD));
        check("l1500_w2", 128'(cap_w[2][63:0]), 128'(64'h00FFDC05BC9A7856));

        build_frame(47, 8'h03, 1'b0, pw, pn);
        build_frame(47, 8'h03, 1'b1, pw2, pn2);
        diffs = 0;
        for (int i = 0; i < pn; i++) if (i != 8 && pw[i] != pw2[i]) diffs++;
        check("corrupt_other_words", 128'(diffs), 128'(0));
        check("corrupt_xor_w8", 128'(pw[8][63:0] ^ pw2[8][63:0]), 128'(64'h0000010000000000));
        run_frame(47, 8'h03, 1'b1);
        check("l47_words", 128'(last_n), 128'(10));
        check("l47_w9_ctrl", 128'(cap_w[9][71:64]), 128'(8'hFE));
        check("l47_w9_term", 128'(cap_w[9][15:8]), 128'(8'hFD));

        le_cnt = 0;
        run_frame(1600, 8'h05, 1'b0);
        check("len_err_pulses", 128'(le_cnt), 128'(1));
        check("l1600_words", 128'(last_n), 128'(191));

        // Random requests, including ones that arrive while busy.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            i_start        = ($urandom_range(0, 3) == 0);
            i_payload_len  = ($urandom_range(0, 1) == 1) ? 11'($urandom_range(0, 80))
                                                         : 11'($urandom_range(0, 1700));
            i_payload_seed = 8'($urandom_range(0, 255));
            i_fcs_corrupt  = ($urandom_range(0, 4) == 0);
        end
        i_start = 1'b0;
        wait_ready(400);

        // Back-to-back frames, then reset in the middle of the fourth.
        @(negedge clk);
        i_rst_n = 1'b0;
        @(negedge clk);
        i_rst_n = 1'b1;
        gap_q.delete();
        i_payload_len  = 11'd60;
        i_payload_seed = 8'h11;
        i_fcs_corrupt  = 1'b0;
        i_start        = 1'b1;
        for (int i = 0; i < 1000 && o_frame_count != 32'd3; i++) @(negedge clk);
        check("b2b_count", 128'(o_frame_count), 128'(3));
        repeat (6) @(negedge clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("midrst_data",  128'(o_tx_data), 128'(IDLE_W));
        check("midrst_ctrl",  128'(o_tx_ctrl), 128'(8'hFF));
        check("midrst_count", 128'(o_frame_count), 128'(0));
        check("midrst_ready", 128'(o_ready), 128'(1));
        check("b2b_gap_n", 128'(gap_q.size()), 128'(3));
        for (int i = 0; i < gap_q.size(); i++) check("b2b_gap", 128'(gap_q[i]), 128'(IPG));
        i_start = 1'b0;
        @(negedge clk);
        i_rst_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
